spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning bits per SPI byte (address+R/W byte and data byte).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cs  input  1  synchronized chip select, active-low; high aborts any transaction.
REQ-005 SHALL have port sclk_rise  input  1  one-clk pulse per conditioned SPI clock rising edge (same pulse drives the shift register's peripheralClkEdge).
REQ-006 SHALL have port sclk_fall  input  1  one-clk pulse per conditioned SPI clock falling edge.
REQ-007 SHALL have port rw_bit  input  1  shift register parallelDataOut[0]; 1=read, 0=write.
REQ-008 SHALL have port addr_we  output  1  one-cycle pulse latching shift register contents as address.
REQ-009 SHALL have port dm_we  output  1  one-cycle data memory write enable.
REQ-010 SHALL have port sr_we  output  1  one-cycle shift register parallelLoad from data memory output.
REQ-011 SHALL have port miso_en  output  1  enables MISO tristate driver.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, GET_ADDR, DECODE, READ_WAIT, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_MEM, DONE.
REQ-014 SHALL use a bit counter of width clog2(BITS+1), cleared on every state entry.
REQ-015 IDLE: cs low -> GET_ADDR next cycle, counter 0; sclk pulses in IDLE not counted.
REQ-016 GET_ADDR: counter increments per sclk_rise; on the clk edge the BITS-th rise is counted -> DECODE.
REQ-017 DECODE (exactly one cycle): addr_we=1; rw_bit=1 -> READ_WAIT, rw_bit=0 -> WRITE_RECV.
REQ-018 READ_WAIT (one cycle, memory read latency): all strobes low -> READ_LOAD.
REQ-019 READ_LOAD (one cycle): sr_we=1 -> READ_SEND.
REQ-020 READ_SEND: miso_en=1; counter increments per sclk_fall; on BITS-th fall -> DONE.
REQ-021 WRITE_RECV: counter increments per sclk_rise; on BITS-th rise -> WRITE_MEM.
REQ-022 WRITE_MEM (one cycle): dm_we=1 -> DONE.
REQ-023 DONE: all strobes and miso_en low; remains until cs high.
REQ-024 cs high in any non-IDLE state SHALL force IDLE on next clk edge, overriding all other transitions; strobes for that cycle follow the current state only.
REQ-025 sclk_rise and sclk_fall both high in one cycle: sclk_rise counted in rise-counting states, sclk_fall ignored; sclk_fall counted in READ_SEND, sclk_rise ignored.
REQ-026 sclk pulses in DECODE, READ_WAIT, READ_LOAD, WRITE_MEM, DONE SHALL be ignored and not carried over.
REQ-027 addr_we, dm_we, sr_we SHALL be Moore outputs decoded from state only; at most one high in any cycle.
REQ-028 Counter SHALL never exceed BITS (no wrap-around).

Reset
REQ-029 reset high SHALL immediately (asynchronously) force IDLE, counter 0, addr_we=dm_we=sr_we=miso_en=busy=0.
REQ-030 After reset deassert, cs already low SHALL start a transaction on the next clk edge (GET_ADDR).
REQ-031 Reset mid-transaction SHALL discard progress; no strobe issued after reset asserts.

Verification
REQ-032 cs low, 8 sclk_rise with rw_bit=0 at 8th -> addr_we pulse 1 cycle, then 8 more rises -> dm_we pulse exactly 1 cycle, sr_we never high, then DONE; cs high -> IDLE, busy=0.
REQ-033 cs low, 8 rises with rw_bit=1 -> addr_we, then 1 idle cycle, then sr_we 1 cycle, miso_en high until 8th sclk_fall, then low; dm_we never high.
REQ-034 cs high after 5 rises in GET_ADDR -> IDLE next cycle, no addr_we; new cs low + 8 rises -> normal addr_we (counter restarted).
REQ-035 reset pulsed during READ_SEND after 3 falls -> miso_en=0 and busy=0 immediately, without waiting for clk; no further strobes.
REQ-036 sclk_rise pulses during DECODE/READ_WAIT/WRITE_MEM -> not counted; write phase still requires 8 further rises before dm_we.
REQ-037 sclk_rise and sclk_fall asserted together every pulse in WRITE_RECV -> dm_we after exactly 8 such cycles.

Source files
------------

// File: rtl/spi_controller.sv
// SPI slave transaction sequencer: address/RW byte, then a read (load + shift out)
// or a write (shift in + memory write). Strobes are Moore outputs of the state.
module spi_controller #(
  parameter int BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic rw_bit,
  output logic addr_we,
  output logic dm_we,
  output logic sr_we,
  output logic miso_en,
  output logic busy
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, DECODE, READ_WAIT, READ_LOAD,
    READ_SEND, WRITE_RECV, WRITE_MEM, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:       if (!cs) state_d = GET_ADDR;
      GET_ADDR:   if (sclk_rise) begin
                    if (cnt_q == LAST) state_d = DECODE;
                    else               cnt_d   = cnt_q + 1'b1;
                  end
      DECODE:     state_d = rw_bit ? READ_WAIT : WRITE_RECV;
      READ_WAIT:  state_d = READ_LOAD;
      READ_LOAD:  state_d = READ_SEND;
      // Only falling edges shift data out; a coincident rise is ignored.
      READ_SEND:  if (sclk_fall) begin
                    if (cnt_q == LAST) state_d = DONE;
                    else               cnt_d   = cnt_q + 1'b1;
                  end
      WRITE_RECV: if (sclk_rise) begin
                    if (cnt_q == LAST) state_d = WRITE_MEM;
                    else               cnt_d   = cnt_q + 1'b1;
                  end
      WRITE_MEM:  state_d = DONE;
      DONE:       state_d = DONE;
      default:    state_d = IDLE;
    endcase
    // Deselect wins over everything; counter restarts on every state entry.
    if (cs && state_q != IDLE) state_d = IDLE;
    if (state_d != state_q)    cnt_d   = '0;
  end

  always_comb begin
    addr_we = (state_q == DECODE);
    sr_we   = (state_q == READ_LOAD);
    dm_we   = (state_q == WRITE_MEM);
    miso_en = (state_q == READ_SEND);
    busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: write, read, abort, async reset, ignored pulses.
module tb_spi_controller;

  logic clk = 1'b0;
  logic reset, cs, sclk_rise, sclk_fall, rw_bit;
  logic addr_we, dm_we, sr_we, miso_en, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_addr = 0, n_dm = 0, n_sr = 0;
  int a0, d0, s0;

  spi_controller #(.BITS(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall), .rw_bit(rw_bit), .addr_we(addr_we),
    .dm_we(dm_we), .sr_we(sr_we), .miso_en(miso_en), .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe-cycle counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (addr_we) n_addr++;
    if (dm_we)   n_dm++;
    if (sr_we)   n_sr++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    a0 = n_addr; d0 = n_dm; s0 = n_sr;
  endtask

  task automatic rises(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_rise = 1'b1; tick();
      sclk_rise = 1'b0; tick();
    end
  endtask

  task automatic falls(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_fall = 1'b1; tick();
      sclk_fall = 1'b0; tick();
    end
  endtask

  // Select, clock in 7 address bits, then the 8th rise lands in DECODE.
  task automatic addr_to_decode(input logic rw);
    cs = 1'b0; rw_bit = rw; tick();
    rises(7);
    sclk_rise = 1'b1; tick();
    sclk_rise = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0; rw_bit = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {addr_we, dm_we, sr_we, miso_en}, 0);
    reset = 1'b0; tick();
    chk("idle_busy", busy, 0);

    // Write transaction
    snap();
    addr_to_decode(1'b0);
    chk("wr_addr_we", addr_we, 1);
    tick();
    chk("wr_addr_we_1cyc", addr_we, 0);
    rises(7);
    chk("wr_no_dm_early", n_dm - d0, 0);
    rises(1);
    chk("wr_dm_once", n_dm - d0, 1);
    chk("wr_sr_never", n_sr - s0, 0);
    chk("wr_addr_once", n_addr - a0, 1);
    tick(); tick();
    chk("wr_done_busy", busy, 1);
    cs = 1'b1; tick();
    chk("wr_idle_busy", busy, 0);

    // Read transaction
    snap();
    addr_to_decode(1'b1);
    chk("rd_addr_we", addr_we, 1);
    tick();
    chk("rd_wait_sr", sr_we, 0);
    chk("rd_wait_miso", miso_en, 0);
    tick();
    chk("rd_load_sr", sr_we, 1);
    tick();
    chk("rd_send_miso", miso_en, 1);
    chk("rd_send_sr", sr_we, 0);
    falls(7);
    chk("rd_miso_7", miso_en, 1);
    sclk_fall = 1'b1; tick(); sclk_fall = 1'b0;
    chk("rd_miso_off", miso_en, 0);
    chk("rd_done_busy", busy, 1);
    chk("rd_sr_once", n_sr - s0, 1);
    chk("rd_dm_never", n_dm - d0, 0);
    cs = 1'b1; tick();

    // Abort mid-address, then a clean address phase must need a full 8 rises
    snap();
    cs = 1'b0; tick();
    rises(5);
    cs = 1'b1; tick();
    chk("abort_busy", busy, 0);
    chk("abort_no_addr", n_addr - a0, 0);
    cs = 1'b0; tick();
    rises(7);
    chk("restart_no_addr", n_addr - a0, 0);
    sclk_rise = 1'b1; tick(); sclk_rise = 1'b0;
    chk("restart_addr_we", addr_we, 1);
    cs = 1'b1; tick(); tick();

    // Async reset during READ_SEND after 3 falls
    addr_to_decode(1'b1);
    tick(); tick(); tick();
    chk("rst_pre_miso", miso_en, 1);
    falls(3);
    reset = 1'b1; #1;
    chk("rst_async_miso", miso_en, 0);
    chk("rst_async_busy", busy, 0);
    snap();
    falls(3); rises(3);
    chk("rst_no_strobes", (n_addr - a0) + (n_dm - d0) + (n_sr - s0), 0);
    reset = 1'b0; tick();
    chk("rst_cs_low_start", busy, 1);
    cs = 1'b1; tick();

    // Rises held through DECODE and WRITE_MEM are not counted
    snap();
    addr_to_decode(1'b0);
    sclk_rise = 1'b1; tick(); sclk_rise = 1'b0; tick();
    rises(7);
    chk("ign_no_dm_7", n_dm - d0, 0);
    sclk_rise = 1'b1; tick(); tick(); sclk_rise = 1'b0; tick();
    chk("ign_dm_8", n_dm - d0, 1);
    cs = 1'b1; tick();

    // Rise and fall together each pulse during the write phase
    snap();
    addr_to_decode(1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      sclk_rise = 1'b1; sclk_fall = 1'b1; tick();
      sclk_rise = 1'b0; sclk_fall = 1'b0; tick();
    end
    chk("both_no_dm_7", n_dm - d0, 0);
    sclk_rise = 1'b1; sclk_fall = 1'b1; tick();
    sclk_rise = 1'b0; sclk_fall = 1'b0;
    chk("both_dm_we", dm_we, 1);
    tick();
    chk("both_dm_once", n_dm - d0, 1);
    cs = 1'b1; tick();
    chk("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
